div_issue_controller: RTL and testbench
=======================================

DIV_ISSUE_CONTROLLER -- requirements
Module: div_issue_controller

Interface
REQ-001 SHALL provide parameter AL_PTR_WIDTH, default 6, active-list index width.
REQ-002 SHALL provide parameter WDOG_LIMIT, default 255, maximum divider-busy cycles before error (used only with DIV_ISSUE_WATCHDOG_EN).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port issueDiv  input  1  div instruction selected by issue stage this cycle.
REQ-006 SHALL have port issuePtr  input  AL_PTR_WIDTH  active-list index of the issued div.
REQ-007 SHALL have port divFree  input  1  divider reports free for next cycle.
REQ-008 SHALL have port opReady  input  1  div operands valid at register read.
REQ-009 SHALL have port divFinished  input  1  divider result available.
REQ-010 SHALL have port replayGrant  input  1  replay queue re-issues the held div this cycle.
REQ-011 SHALL have ports flushValid 1, flushAll 1, flushHead AL_PTR_WIDTH, flushTail AL_PTR_WIDTH (all inputs): selective flush range.
REQ-012 SHALL have port divAcquire  output  1, and acquirePtr  output  AL_PTR_WIDTH: reservation request to divider.
REQ-013 SHALL have port divReq  output  1  start division.
REQ-014 SHALL have port divRelease  output  1  result consumed, divider may free.
REQ-015 SHALL have ports issueBlock  output  1 (scheduler must not select another div), replayReq  output  1 (ask replay queue to issue held div), wdogErr  output  1.

Function
REQ-016 SHALL implement FSM states IDLE, ACQUIRED, REQUESTED, REPLAY; held pointer register heldPtr.
REQ-017 IDLE: issueDiv && divFree && !flushHit(issuePtr) SHALL assert divAcquire combinationally same cycle, acquirePtr=issuePtr, latch heldPtr, go ACQUIRED.
REQ-018 issueDiv in any non-IDLE state or with divFree=0 SHALL be ignored (no acquire, no state change).
REQ-019 ACQUIRED: opReady SHALL assert divReq combinationally for exactly that cycle and go REQUESTED; otherwise remain.
REQ-020 REQUESTED: divFinished SHALL go REPLAY next cycle.
REQ-021 REPLAY: replayReq SHALL be 1; replayGrant SHALL assert divRelease combinationally for one cycle and go IDLE.
REQ-022 issueBlock SHALL equal (state != IDLE).
REQ-023 flushHit(p): flushValid && (flushAll || (head<=tail ? head<=p<tail : p>=head || p<tail)); head==tail without flushAll SHALL hit nothing.
REQ-024 flushHit(heldPtr) in any non-IDLE state SHALL force IDLE next cycle, suppress divReq/divRelease/replayReq that cycle, no release pulse (divider frees itself on flush).
REQ-025 Flush SHALL take priority over divFinished, opReady and replayGrant in the same cycle.
REQ-026 divAcquire, divReq, divRelease SHALL never be asserted in the same cycle.

Reset
REQ-027 rst SHALL force IDLE, heldPtr=0, watchdog counter=0, wdogErr=0; all outputs 0 during and after reset until stimulus; reset mid-operation abandons the div without divRelease.

Configuration
REQ-028 With DIV_ISSUE_WATCHDOG_EN defined: counter clears on entering REQUESTED, increments each REQUESTED cycle, saturates; reaching WDOG_LIMIT without divFinished SHALL set wdogErr sticky until rst; FSM behaviour unchanged.
REQ-029 Without DIV_ISSUE_WATCHDOG_EN: no counter logic, wdogErr tied 0.

Verification
REQ-030 Normal: reset; issueDiv=1, issuePtr=5, divFree=1 -> divAcquire=1, acquirePtr=5; opReady next cycle -> divReq one cycle; divFinished after 34 cycles -> replayReq=1; replayGrant -> divRelease one cycle, IDLE, issueBlock=0.
REQ-031 Blocking: while REQUESTED, issueDiv=1, issuePtr=9 -> no divAcquire, heldPtr stays 5, issueBlock=1.
REQ-032 Wrap flush: heldPtr=62, flushHead=60, flushTail=3 -> IDLE next cycle, no divRelease; heldPtr=10, same range -> unaffected.
REQ-033 Simultaneous: divFinished=1 and flushHit(heldPtr) same cycle -> IDLE, replayReq never 1; flushAll with head==tail=0 -> IDLE.
REQ-034 Watchdog (macro defined, WDOG_LIMIT=4): divReq then no divFinished for 4 cycles -> wdogErr=1, stays 1 after completion until rst; macro undefined -> wdogErr=0 throughout.
REQ-035 Reset mid-operation: rst asserted in REPLAY -> next cycle IDLE, replayReq=0, divRelease=0.

Source files
------------

// File: rtl/div_issue_controller_if.sv
// Issue/divider/replay/flush signal bundle for div_issue_controller.
// slave = controller side, master = surrounding pipeline/divider side.
interface div_issue_controller_if #(
  parameter int unsigned AL_PTR_WIDTH = 6
);
  logic                    issueDiv;
  logic [AL_PTR_WIDTH-1:0] issuePtr;
  logic                    divFree;
  logic                    opReady;
  logic                    divFinished;
  logic                    replayGrant;
  logic                    flushValid;
  logic                    flushAll;
  logic [AL_PTR_WIDTH-1:0] flushHead;
  logic [AL_PTR_WIDTH-1:0] flushTail;
  logic                    divAcquire;
  logic [AL_PTR_WIDTH-1:0] acquirePtr;
  logic                    divReq;
  logic                    divRelease;
  logic                    issueBlock;
  logic                    replayReq;
  logic                    wdogErr;

  modport slave (
    input  issueDiv, issuePtr, divFree, opReady, divFinished, replayGrant,
           flushValid, flushAll, flushHead, flushTail,
    output divAcquire, acquirePtr, divReq, divRelease, issueBlock, replayReq,
           wdogErr
  );

  modport master (
    output issueDiv, issuePtr, divFree, opReady, divFinished, replayGrant,
           flushValid, flushAll, flushHead, flushTail,
    input  divAcquire, acquirePtr, divReq, divRelease, issueBlock, replayReq,
           wdogErr
  );
endinterface

// File: rtl/div_issue_controller.sv
// Single-divider issue controller: acquire -> request -> replay -> release, with selective flush.
// Optional busy watchdog enabled by defining DIV_ISSUE_WATCHDOG_EN.
module div_issue_controller #(
  parameter int unsigned AL_PTR_WIDTH = 6,
  parameter int unsigned WDOG_LIMIT   = 255
) (
  input logic                   clk,
  input logic                   rst,
  div_issue_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACQUIRED, REQUESTED, REPLAY} state_e;

  state_e                  state_q, state_d;
  logic [AL_PTR_WIDTH-1:0] heldPtr_q, heldPtr_d;
  logic                    acquire_ok;
  logic                    held_flush;

  // Range is [head, tail) and may wrap; head==tail is empty unless flushAll.
  function automatic logic flush_hit(input logic                    valid,
                                     input logic                    all,
                                     input logic [AL_PTR_WIDTH-1:0] head,
                                     input logic [AL_PTR_WIDTH-1:0] tail,
                                     input logic [AL_PTR_WIDTH-1:0] p);
    logic in_range;
    if (head <= tail) in_range = (p >= head) && (p < tail);
    else              in_range = (p >= head) || (p < tail);
    return valid && (all || in_range);
  endfunction

  always_comb begin
    acquire_ok = bus.issueDiv && bus.divFree &&
                 !flush_hit(bus.flushValid, bus.flushAll, bus.flushHead,
                            bus.flushTail, bus.issuePtr);
    held_flush = flush_hit(bus.flushValid, bus.flushAll, bus.flushHead,
                           bus.flushTail, heldPtr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      heldPtr_q <= '0;
    end else begin
      state_q   <= state_d;
      heldPtr_q <= heldPtr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    heldPtr_d = heldPtr_q;
    unique case (state_q)
      IDLE: begin
        if (acquire_ok) begin
          state_d   = ACQUIRED;
          heldPtr_d = bus.issuePtr;
        end
      end
      ACQUIRED: begin
        if (held_flush)       state_d = IDLE;
        else if (bus.opReady) state_d = REQUESTED;
      end
      REQUESTED: begin
        if (held_flush)           state_d = IDLE;
        else if (bus.divFinished) state_d = REPLAY;
      end
      REPLAY: begin
        if (held_flush || bus.replayGrant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_ISSUE_WATCHDOG_EN
  localparam int unsigned WCW = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
  localparam logic [WCW-1:0] WLIM = WCW'(WDOG_LIMIT);

  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           werr_q, werr_d;

  always_comb begin
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    if (state_q == ACQUIRED && state_d == REQUESTED) begin
      wcnt_d = '0;
    end else if (state_q == REQUESTED && wcnt_q != WLIM) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    // Staying in REQUESTED means no divFinished and no flush this cycle.
    if (state_q == REQUESTED && state_d == REQUESTED && wcnt_d == WLIM) begin
      werr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end
`endif

  always_comb begin
    bus.divAcquire = 1'b0;
    bus.acquirePtr = '0;
    bus.divReq     = 1'b0;
    bus.divRelease = 1'b0;
    bus.replayReq  = 1'b0;
    bus.issueBlock = 1'b0;
`ifdef DIV_ISSUE_WATCHDOG_EN
    bus.wdogErr    = werr_q;
`else
    bus.wdogErr    = 1'b0 && (WDOG_LIMIT == 0);
`endif
    if (!rst) begin
      bus.issueBlock = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (acquire_ok) begin
            bus.divAcquire = 1'b1;
            bus.acquirePtr = bus.issuePtr;
          end
        end
        ACQUIRED:  bus.divReq = bus.opReady && !held_flush;
        REQUESTED: ;
        REPLAY: begin
          bus.replayReq  = !held_flush;
          bus.divRelease = bus.replayGrant && !held_flush;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_controller.sv
// Directed bench for div_issue_controller; wdogErr expectation follows DIV_ISSUE_WATCHDOG_EN.
module tb_div_issue_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_ISSUE_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  div_issue_controller_if #(.AL_PTR_WIDTH(6)) bus ();

  div_issue_controller #(
    .AL_PTR_WIDTH(6),
    .WDOG_LIMIT  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.issueDiv    = 1'b0;
    bus.issuePtr    = '0;
    bus.divFree     = 1'b0;
    bus.opReady     = 1'b0;
    bus.divFinished = 1'b0;
    bus.replayGrant = 1'b0;
    bus.flushValid  = 1'b0;
    bus.flushAll    = 1'b0;
    bus.flushHead   = '0;
    bus.flushTail   = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic acquire(input logic [5:0] p);
    bus.issueDiv = 1'b1;
    bus.issuePtr = p;
    bus.divFree  = 1'b1;
    tick();
    bus.issueDiv = 1'b0;
    bus.divFree  = 1'b0;
  endtask

  task automatic to_requested;
    bus.opReady = 1'b1;
    tick();
    bus.opReady = 1'b0;
  endtask

  task automatic to_replay;
    bus.divFinished = 1'b1;
    tick();
    bus.divFinished = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    bus.issueDiv = 1'b1;
    bus.divFree  = 1'b1;
    bus.issuePtr = 6'd5;
    tick();
    tick();
    #1;
    checks++;
    if ({bus.divAcquire, bus.divReq, bus.divRelease, bus.issueBlock,
         bus.replayReq, bus.wdogErr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_during_outputs: got %b want 000000",
               {bus.divAcquire, bus.divReq, bus.divRelease, bus.issueBlock,
                bus.replayReq, bus.wdogErr});
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({bus.divAcquire, bus.divReq, bus.divRelease, bus.issueBlock,
         bus.replayReq, bus.wdogErr, bus.acquirePtr} !== 12'b0) begin
      errors++;
      $display("FAIL reset_after_outputs: got %b want all zero",
               {bus.divAcquire, bus.divReq, bus.divRelease, bus.issueBlock,
                bus.replayReq, bus.wdogErr, bus.acquirePtr});
    end
  endtask

  task automatic test_normal;
    do_reset();
    bus.issueDiv = 1'b1;
    bus.issuePtr = 6'd5;
    bus.divFree  = 1'b1;
    #1;
    checks++;
    if (bus.divAcquire !== 1'b1 || bus.acquirePtr !== 6'd5) begin
      errors++;
      $display("FAIL norm_acquire: got acq=%b ptr=%0d want acq=1 ptr=5",
               bus.divAcquire, bus.acquirePtr);
    end
    tick();
    bus.issueDiv = 1'b0;
    bus.divFree  = 1'b0;
    #1;
    checks++;
    if (bus.issueBlock !== 1'b1 || bus.divReq !== 1'b0 || bus.divAcquire !== 1'b0) begin
      errors++;
      $display("FAIL norm_acquired: got blk=%b req=%b acq=%b want 1 0 0",
               bus.issueBlock, bus.divReq, bus.divAcquire);
    end
    bus.opReady = 1'b1;
    #1;
    checks++;
    if (bus.divReq !== 1'b1 || bus.divAcquire !== 1'b0 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL norm_divreq: got req=%b acq=%b rel=%b want 1 0 0",
               bus.divReq, bus.divAcquire, bus.divRelease);
    end
    tick();
    #1;
    checks++;
    if (bus.divReq !== 1'b0) begin
      errors++;
      $display("FAIL norm_divreq_once: got %b want 0", bus.divReq);
    end
    bus.opReady = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    checks++;
    if (bus.replayReq !== 1'b0 || bus.issueBlock !== 1'b1) begin
      errors++;
      $display("FAIL norm_busy: got rr=%b blk=%b want 0 1", bus.replayReq, bus.issueBlock);
    end
    to_replay();
    #1;
    checks++;
    if (bus.replayReq !== 1'b1 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL norm_replayreq: got rr=%b rel=%b want 1 0", bus.replayReq, bus.divRelease);
    end
    bus.replayGrant = 1'b1;
    #1;
    checks++;
    if (bus.divRelease !== 1'b1 || bus.divReq !== 1'b0 || bus.divAcquire !== 1'b0) begin
      errors++;
      $display("FAIL norm_release: got rel=%b req=%b acq=%b want 1 0 0",
               bus.divRelease, bus.divReq, bus.divAcquire);
    end
    tick();
    bus.replayGrant = 1'b0;
    #1;
    checks++;
    if (bus.issueBlock !== 1'b0 || bus.divRelease !== 1'b0 || bus.replayReq !== 1'b0) begin
      errors++;
      $display("FAIL norm_idle: got blk=%b rel=%b rr=%b want 0 0 0",
               bus.issueBlock, bus.divRelease, bus.replayReq);
    end
  endtask

  task automatic test_blocking;
    do_reset();
    acquire(6'd5);
    to_requested();
    bus.issueDiv = 1'b1;
    bus.issuePtr = 6'd9;
    bus.divFree  = 1'b1;
    #1;
    checks++;
    if (bus.divAcquire !== 1'b0) begin
      errors++;
      $display("FAIL block_acquire: got %b want 0", bus.divAcquire);
    end
    tick();
    checks++;
    if (dut.heldPtr_q !== 6'd5 || bus.issueBlock !== 1'b1) begin
      errors++;
      $display("FAIL block_held: got ptr=%0d blk=%b want 5 1", dut.heldPtr_q, bus.issueBlock);
    end
    // Not-free divider is ignored in IDLE too.
    do_reset();
    bus.issueDiv = 1'b1;
    bus.issuePtr = 6'd9;
    bus.divFree  = 1'b0;
    #1;
    checks++;
    if (bus.divAcquire !== 1'b0) begin
      errors++;
      $display("FAIL block_notfree: got %b want 0", bus.divAcquire);
    end
    tick();
    checks++;
    if (bus.issueBlock !== 1'b0) begin
      errors++;
      $display("FAIL block_notfree_state: got %b want 0", bus.issueBlock);
    end
  endtask

  task automatic test_wrap_flush;
    do_reset();
    acquire(6'd62);
    bus.flushValid = 1'b1;
    bus.flushHead  = 6'd60;
    bus.flushTail  = 6'd3;
    bus.opReady    = 1'b1;
    #1;
    checks++;
    if (bus.divReq !== 1'b0 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL wrap_suppress: got req=%b rel=%b want 0 0", bus.divReq, bus.divRelease);
    end
    tick();
    bus.opReady = 1'b0;
    checks++;
    if (bus.issueBlock !== 1'b0 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL wrap_hit_idle: got blk=%b rel=%b want 0 0", bus.issueBlock, bus.divRelease);
    end
    bus.flushValid = 1'b0;
    acquire(6'd10);
    bus.flushValid = 1'b1;
    tick();
    checks++;
    if (bus.issueBlock !== 1'b1) begin
      errors++;
      $display("FAIL wrap_miss: got blk=%b want 1", bus.issueBlock);
    end
    // Issue-side filter: tail is exclusive, head is inclusive.
    do_reset();
    bus.flushValid = 1'b1;
    bus.flushHead  = 6'd60;
    bus.flushTail  = 6'd3;
    bus.issueDiv   = 1'b1;
    bus.divFree    = 1'b1;
    bus.issuePtr   = 6'd60;
    #1;
    checks++;
    if (bus.divAcquire !== 1'b0) begin
      errors++;
      $display("FAIL wrap_issue_head: got %b want 0", bus.divAcquire);
    end
    bus.issuePtr = 6'd3;
    #1;
    checks++;
    if (bus.divAcquire !== 1'b1 || bus.acquirePtr !== 6'd3) begin
      errors++;
      $display("FAIL wrap_issue_tail: got acq=%b ptr=%0d want 1 3", bus.divAcquire, bus.acquirePtr);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    acquire(6'd62);
    to_requested();
    bus.divFinished = 1'b1;
    bus.flushValid  = 1'b1;
    bus.flushHead   = 6'd60;
    bus.flushTail   = 6'd3;
    tick();
    bus.divFinished = 1'b0;
    bus.flushValid  = 1'b0;
    #1;
    checks++;
    if (bus.issueBlock !== 1'b0 || bus.replayReq !== 1'b0) begin
      errors++;
      $display("FAIL simul_finish_flush: got blk=%b rr=%b want 0 0", bus.issueBlock, bus.replayReq);
    end
    acquire(6'd7);
    bus.flushValid = 1'b1;
    bus.flushHead  = 6'd7;
    bus.flushTail  = 6'd7;
    tick();
    checks++;
    if (bus.issueBlock !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_range: got blk=%b want 1", bus.issueBlock);
    end
    bus.flushAll  = 1'b1;
    bus.flushHead = 6'd0;
    bus.flushTail = 6'd0;
    tick();
    checks++;
    if (bus.issueBlock !== 1'b0 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL simul_flushall: got blk=%b rel=%b want 0 0", bus.issueBlock, bus.divRelease);
    end
  endtask

  task automatic test_watchdog;
    do_reset();
    acquire(6'd20);
    to_requested();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.wdogErr !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early: got %b want 0", bus.wdogErr);
    end
    tick();
    checks++;
    if (bus.wdogErr !== WD_EXP) begin
      errors++;
      $display("FAIL wdog_fire: got %b want %b", bus.wdogErr, WD_EXP);
    end
    to_replay();
    bus.replayGrant = 1'b1;
    tick();
    bus.replayGrant = 1'b0;
    checks++;
    if (bus.wdogErr !== WD_EXP || bus.issueBlock !== 1'b0) begin
      errors++;
      $display("FAIL wdog_sticky: got err=%b blk=%b want %b 0", bus.wdogErr, bus.issueBlock, WD_EXP);
    end
    do_reset();
    checks++;
    if (bus.wdogErr !== 1'b0) begin
      errors++;
      $display("FAIL wdog_reset: got %b want 0", bus.wdogErr);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    acquire(6'd5);
    to_requested();
    to_replay();
    rst = 1'b1;
    bus.replayGrant = 1'b1;
    #1;
    checks++;
    if (bus.divRelease !== 1'b0 || bus.replayReq !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during: got rel=%b rr=%b want 0 0", bus.divRelease, bus.replayReq);
    end
    tick();
    rst = 1'b0;
    bus.replayGrant = 1'b0;
    #1;
    checks++;
    if (bus.issueBlock !== 1'b0 || bus.replayReq !== 1'b0 || bus.divRelease !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got blk=%b rr=%b rel=%b want 0 0 0",
               bus.issueBlock, bus.replayReq, bus.divRelease);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_normal();
    test_blocking();
    test_wrap_flush();
    test_simultaneous();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
